// File: rtl/bit_serializer_pkg.sv
// Shared types and helpers for the bit serializer front end.
package bit_serializer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } ser_state_t;

    localparam int SER_MAX_GAP = 15;
    localparam int SER_MAX_W   = 32;

    function automatic logic even_parity(input logic [SER_MAX_W-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/bit_serializer_fsm_down_counter.sv
// Loadable down counter that saturates at zero; used for bit and gap counting.
module down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             is_zero
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign is_zero = (count == '0);

endmodule

// File: rtl/bit_serializer_fsm.sv
// MSB-first parallel-to-serial converter with valid/ready input and optional idle gap.
// Optional even-parity trailer bit: define BIT_SERIALIZER_PARITY_EN.
module bit_serializer_fsm
    import bit_serializer_pkg::*;
#(
    parameter int W   = 8,
    parameter int GAP = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         out_bit,
    output logic         out_valid,
    output logic         out_last,
    output logic         busy
);

`ifdef BIT_SERIALIZER_PARITY_EN
    localparam int FRAME = W + 1;
`else
    localparam int FRAME = W;
`endif
    localparam int CNT_W = $clog2(FRAME);
    localparam int GAP_W = $clog2(SER_MAX_GAP + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FRAME - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = (GAP > 0) ? GAP_W'(GAP - 1) : '0;

    if (GAP < 0 || GAP > SER_MAX_GAP) begin : g_bad_gap
        $error("GAP out of range");
    end
    if (W < 2 || W > SER_MAX_W) begin : g_bad_w
        $error("W out of range");
    end

    // The module parameter GAP shadows the package state literal, so the
    // state is always referenced with its package scope.
    ser_state_t state, state_d;

    logic [FRAME-1:0] frame_word;
    logic [FRAME-1:0] sr;
    logic [CNT_W-1:0] bit_count;
    logic [GAP_W-1:0] gap_count_unused;
    logic             bit_zero, gap_zero;
    logic             load, bit_dec, gap_load, gap_dec;

`ifdef BIT_SERIALIZER_PARITY_EN
    assign frame_word = {in_data, even_parity(SER_MAX_W'(in_data))};
`else
    assign frame_word = in_data;
`endif

    down_counter #(.WIDTH(CNT_W)) u_bit_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (CNT_LOAD),
        .dec      (bit_dec),
        .count    (bit_count),
        .is_zero  (bit_zero)
    );

    down_counter #(.WIDTH(GAP_W)) u_gap_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (gap_load),
        .load_val (GAP_LOAD),
        .dec      (gap_dec),
        .count    (gap_count_unused),
        .is_zero  (gap_zero)
    );

    always_comb begin
        state_d  = state;
        in_ready = 1'b0;
        load     = 1'b0;
        bit_dec  = 1'b0;
        gap_load = 1'b0;
        gap_dec  = 1'b0;
        case (state)
            bit_serializer_pkg::IDLE: begin
                in_ready = rst_n;
                if (in_valid && rst_n) begin
                    load    = 1'b1;
                    state_d = bit_serializer_pkg::SHIFT;
                end
            end
            bit_serializer_pkg::SHIFT: begin
                if (!bit_zero) begin
                    bit_dec = 1'b1;
                end else if (GAP > 0) begin
                    gap_load = 1'b1;
                    state_d  = bit_serializer_pkg::GAP;
                end else begin
                    // Last bit with no gap: accept the next word for a bubble-free stream.
                    in_ready = rst_n;
                    if (in_valid && rst_n) begin
                        load = 1'b1;
                    end else begin
                        state_d = bit_serializer_pkg::IDLE;
                    end
                end
            end
            bit_serializer_pkg::GAP: begin
                if (gap_zero) begin
                    state_d = bit_serializer_pkg::IDLE;
                end else begin
                    gap_dec = 1'b1;
                end
            end
            default: state_d = bit_serializer_pkg::IDLE;
        endcase
    end

    // Outputs are registered against the next state so they line up with the counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= bit_serializer_pkg::IDLE;
            sr        <= '0;
            out_bit   <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            state <= state_d;
            if (load) begin
                sr        <= frame_word << 1;
                out_bit   <= frame_word[FRAME-1];
                out_valid <= 1'b1;
                out_last  <= 1'b0;
            end else if (state_d == bit_serializer_pkg::SHIFT) begin
                sr        <= sr << 1;
                out_bit   <= sr[FRAME-1];
                out_valid <= 1'b1;
                out_last  <= (bit_count == CNT_W'(1));
            end else begin
                out_bit   <= 1'b0;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

    assign busy = (state != bit_serializer_pkg::IDLE);

endmodule

// File: tb/tb_bit_serializer_fsm.sv
// Scoreboard bench for bit_serializer_fsm: W=6/GAP=0, W=8/GAP=0 and W=8/GAP=3 instances.
module tb_bit_serializer_fsm;

`ifdef BIT_SERIALIZER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int F6 = 6 + PAR;
    localparam int F8 = 8 + PAR;

    typedef struct packed { logic b; logic last; } exp_t;
    typedef struct { logic [7:0] data; logic [7:0] bits; logic par; } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [5:0] d6;
    logic [7:0] d8, dg;
    logic iv6, iv8, ivg;
    logic r6, r8, rg, ob6, ob8, obg, ov6, ov8, ovg, ol6, ol8, olg, bz6, bz8, bzg;

    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;
    exp_t q6[$], q8[$], qg[$];
    exp_t e6, e8, eg;
    vec_t tab[8];

    always #5 clk = ~clk;

    bit_serializer_fsm #(.W(6), .GAP(0)) u6 (
        .clk(clk), .rst_n(rst_n), .in_data(d6), .in_valid(iv6), .in_ready(r6),
        .out_bit(ob6), .out_valid(ov6), .out_last(ol6), .busy(bz6));
    bit_serializer_fsm #(.W(8), .GAP(0)) u8 (
        .clk(clk), .rst_n(rst_n), .in_data(d8), .in_valid(iv8), .in_ready(r8),
        .out_bit(ob8), .out_valid(ov8), .out_last(ol8), .busy(bz8));
    bit_serializer_fsm #(.W(8), .GAP(3)) ug (
        .clk(clk), .rst_n(rst_n), .in_data(dg), .in_valid(ivg), .in_ready(rg),
        .out_bit(obg), .out_valid(ovg), .out_last(olg), .busy(bzg));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic extra(input string name);
        checks++;
        errors++;
        $display("FAIL %s: unexpected valid bit at %0t", name, $time);
    endtask

    function automatic logic model_par(input logic [31:0] d);
        return ^d;
    endfunction

    // Expected frame: data bits MSB first, then the parity bit when enabled.
    task automatic push(input int inst, input logic [31:0] bits, input int w, input logic par);
        exp_t e;
        for (int i = w - 1; i >= 0; i--) begin
            e.b = bits[i];
            e.last = (i == 0) && (PAR == 0);
            if (inst == 0) q6.push_back(e); else if (inst == 1) q8.push_back(e); else qg.push_back(e);
        end
        if (PAR == 1) begin
            e.b = par;
            e.last = 1'b1;
            if (inst == 0) q6.push_back(e); else if (inst == 1) q8.push_back(e); else qg.push_back(e);
        end
    endtask

    task automatic wait_hs8();
        int n = 0;
        @(negedge clk);
        while (!r8 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("hs8_timeout", r8, 1);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) if (mon_en) begin
        if (ov6) begin
            if (q6.size() == 0) extra("u6_extra");
            else begin e6 = q6.pop_front(); chk("u6_bit_last", {ob6, ol6}, {e6.b, e6.last}); end
        end else chk("u6_idle_zero", {ob6, ol6}, 2'b00);
    end

    always @(negedge clk) if (mon_en) begin
        if (ov8) begin
            if (q8.size() == 0) extra("u8_extra");
            else begin e8 = q8.pop_front(); chk("u8_bit_last", {ob8, ol8}, {e8.b, e8.last}); end
        end else chk("u8_idle_zero", {ob8, ol8}, 2'b00);
    end

    always @(negedge clk) if (mon_en) begin
        if (ovg) begin
            if (qg.size() == 0) extra("ug_extra");
            else begin eg = qg.pop_front(); chk("ug_bit_last", {obg, olg}, {eg.b, eg.last}); end
        end else chk("ug_idle_zero", {obg, olg}, 2'b00);
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tab[0] = '{8'hA5, 8'b1010_0101, 1'b0};
        tab[1] = '{8'h07, 8'b0000_0111, 1'b1};
        tab[2] = '{8'h03, 8'b0000_0011, 1'b0};
        tab[3] = '{8'hFF, 8'b1111_1111, 1'b0};
        tab[4] = '{8'h80, 8'b1000_0000, 1'b1};
        tab[5] = '{8'h01, 8'b0000_0001, 1'b1};
        tab[6] = '{8'hC1, 8'b1100_0001, 1'b1};
        tab[7] = '{8'h5A, 8'b0101_1010, 1'b0};

        rst_n = 1'b0;
        d6 = '0; d8 = '0; dg = '0;
        iv6 = 1'b1; iv8 = 1'b1; ivg = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready_low", {r6, r8, rg}, 3'b000);
        chk("rst_outputs", {ov6, ov8, ovg, ol6, ol8, olg, bz6, bz8, bzg}, 9'd0);
        iv6 = 1'b0; iv8 = 1'b0; ivg = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", {r6, r8, rg}, 3'b111);
        chk("idle_after_rst", {bz6, bz8, bzg}, 3'b000);

        // W=6 single pulse: six bits, last on the final one, idle after.
        @(posedge clk); #1;
        d6 = 6'b110011; iv6 = 1'b1;
        push(0, 32'b110011, 6, model_par(32'b110011));
        @(posedge clk); #1;
        iv6 = 1'b0; d6 = '0;
        for (int k = 1; k <= F6; k++) begin
            @(negedge clk);
            chk("w6_valid", ov6, 1);
            chk("w6_last", ol6, (k == F6));
        end
        @(negedge clk);
        chk("w6_idle_after", {bz6, r6, ov6}, 3'b010);

        // Back-to-back A5 / 3C with in_valid held: no bubble.
        @(posedge clk); #1;
        d8 = 8'hA5; iv8 = 1'b1;
        push(1, 32'hA5, 8, model_par(32'hA5));
        push(1, 32'h3C, 8, model_par(32'h3C));
        @(posedge clk); #1;
        d8 = 8'h3C;
        for (int k = 1; k <= 2 * F8; k++) begin
            @(negedge clk);
            chk("b2b_valid", ov8, 1);
            chk("b2b_last", ol8, (k == F8) || (k == 2 * F8));
            if (k == F8) begin
                chk("b2b_ready_last", r8, 1);
                @(posedge clk); #1;
                iv8 = 1'b0;
            end
        end
        @(negedge clk);
        chk("b2b_idle", {bz8, ov8}, 2'b00);

        // GAP=3 with a second word queued.
        @(posedge clk); #1;
        dg = 8'h96; ivg = 1'b1;
        push(2, 32'h96, 8, model_par(32'h96));
        push(2, 32'h69, 8, model_par(32'h69));
        @(posedge clk); #1;
        dg = 8'h69;
        for (int k = 1; k <= F8 + 4; k++) begin
            @(negedge clk);
            if (k <= F8) chk("gap_frame_vr", {ovg, rg}, 2'b10);
            else if (k <= F8 + 3) chk("gap_idle_vrb", {ovg, rg, bzg}, 3'b001);
            else chk("gap_ready_vrb", {ovg, rg, bzg}, 3'b010);
        end
        @(posedge clk); #1;
        ivg = 1'b0;
        @(negedge clk);
        chk("gap_next_first", ovg, 1);
        repeat (F8 + 6) @(posedge clk);

        // Table stream through the W=8 instance with in_valid held.
        for (int i = 0; i < 8; i++) push(1, {24'd0, tab[i].bits}, 8, tab[i].par);
        @(posedge clk); #1;
        iv8 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            d8 = tab[i].data;
            wait_hs8();
        end
        iv8 = 1'b0;
        repeat (F8 + 3) @(posedge clk);

        // Reset during cycle 4 of a frame discards the rest.
        @(posedge clk); #1;
        d8 = 8'hF0; iv8 = 1'b1;
        push(1, 32'hF0, 8, model_par(32'hF0));
        @(posedge clk); #1;
        iv8 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        #1 q8.delete();
        @(negedge clk);
        chk("midrst_outputs", {ov8, ol8, bz8, r8}, 4'b0000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_ready", {r8, bz8}, 2'b10);
        @(posedge clk); #1;
        d8 = 8'h5A; iv8 = 1'b1;
        push(1, 32'h5A, 8, model_par(32'h5A));
        @(posedge clk); #1;
        iv8 = 1'b0;
        repeat (F8 + 2) @(posedge clk);

        // in_valid toggling and in_data churn during SHIFT.
        #1;
        d8 = 8'hC3; iv8 = 1'b1;
        push(1, 32'hC3, 8, model_par(32'hC3));
        @(posedge clk); #1;
        for (int k = 1; k <= F8; k++) begin
            iv8 = (k < F8) ? k[0] : 1'b0;
            d8 = 8'($urandom);
            @(negedge clk);
            chk("tog_ready", r8, (k == F8));
            chk("tog_busy", bz8, 1);
            @(posedge clk); #1;
        end
        iv8 = 1'b0;
        @(negedge clk);
        chk("tog_no_extra_hs", {bz8, ov8}, 2'b00);
        repeat (3) @(posedge clk);

        @(negedge clk);
        chk("q6_drained", q6.size(), 0);
        chk("q8_drained", q8.size(), 0);
        chk("qg_drained", qg.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
